// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - SPARC PC/nPC sequencer with delayed-branch and annul handling
//
// Purpose: holds the PC/nPC pair, advances it every non-stalled cycle, follows
// branch targets one instruction late (delay slot), squashes annulled delay
// slots and accepts JMPL/trap redirects.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   stall             freeze PC, nPC, state and counter (redirect overrides)
//   cti_valid         instruction at pc is a branch/call
//   taken, uncond     branch condition met / branch always taken (BA, CALL)
//   annul_bit         instruction a-bit
//   target            branch target from the branch-target adder
//   redirect          JMPL/trap redirect, wins over everything but reset
//   redirect_addr     redirect destination
//   pc, npc           registered fetch address and next fetch address
//   slot_valid        1 when the instruction at pc is to execute
//   taken_count       taken-branch counter
//
// Build option: PC_SEQ_TAKEN_COUNT_EN enables the taken-branch counter; when
// it is not defined taken_count is constant zero and no counter flops exist.

module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        cti_valid,
    input  logic        taken,
    input  logic        uncond,
    input  logic        annul_bit,
    input  logic [31:0] target,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    output logic [31:0] pc,
    output logic [31:0] npc,
    output logic        slot_valid,
    output logic [31:0] taken_count
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SQUASH = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_nxt;
    logic [31:0] pc_q;
    logic [31:0] npc_q;
    logic [31:0] pc_nxt;
    logic [31:0] npc_nxt;

    // Word-align loaded addresses; the two low bits are never meaningful.
    logic [31:0] target_al;
    logic [31:0] redirect_al;
    logic [31:0] npc_inc;
    logic        br_take;
    logic        cti_fire;

    assign target_al   = target & 32'hFFFF_FFFC;
    assign redirect_al = redirect_addr & 32'hFFFF_FFFC;
    assign npc_inc     = npc_q + 32'd4;
    assign br_take     = taken | uncond;
    // A CTI only acts when its slot executes, i.e. in RUN with no stall/redirect.
    assign cti_fire    = !redirect && !stall && (state_q == ST_RUN) && cti_valid;

    // State and PC registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            npc_q   <= RESET_PC + 32'd4;
        end else begin
            state_q <= state_nxt;
            pc_q    <= pc_nxt;
            npc_q   <= npc_nxt;
        end
    end

    // Next-state and next-PC logic
    always_comb begin
        state_nxt = state_q;
        pc_nxt    = pc_q;
        npc_nxt   = npc_q;
        if (redirect) begin
            // Redirect drops any pending squash and resumes valid execution.
            state_nxt = ST_RUN;
            pc_nxt    = redirect_al;
            npc_nxt   = redirect_al + 32'd4;
        end else if (!stall) begin
            case (state_q)
                ST_BOOT: begin
                    state_nxt = ST_RUN;
                end
                ST_SQUASH: begin
                    state_nxt = ST_RUN;
                    pc_nxt    = npc_q;
                    npc_nxt   = npc_inc;
                end
                ST_RUN: begin
                    pc_nxt = npc_q;
                    if (cti_valid) begin
                        npc_nxt = br_take ? target_al : npc_inc;
                        // Delay slot is annulled for untaken conditionals and
                        // for BA/CALL with the a-bit set.
                        if (annul_bit && (!taken || uncond)) begin
                            state_nxt = ST_SQUASH;
                        end
                    end else begin
                        npc_nxt = npc_inc;
                    end
                end
                default: begin
                    state_nxt = ST_BOOT;
                end
            endcase
        end
    end

    // Outputs: decoded from registers only, no input-to-output path
    always_comb begin
        slot_valid = (state_q == ST_RUN);
        pc         = pc_q;
        npc        = npc_q;
    end

`ifdef PC_SEQ_TAKEN_COUNT_EN
    logic [31:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 32'd0;
        end else if (cti_fire && br_take) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign taken_count = count_q;
`else
    logic unused_fire;
    assign unused_fire = cti_fire;
    assign taken_count = 32'd0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer

module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        cti_valid;
    logic        taken;
    logic        uncond;
    logic        annul_bit;
    logic [31:0] target;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        slot_valid;
    logic [31:0] taken_count;

    int n_checks;
    int n_fail;
    bit chk_en;

    // Reference model: where fetch is, where it goes next, whether the
    // sequencer has come out of reset yet, and whether the slot at pc is
    // an annulled delay slot.
    logic [31:0] m_pc;
    logic [31:0] m_npc;
    logic [31:0] m_cnt;
    bit          m_started;
    bit          m_annulled;

    pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .cti_valid    (cti_valid),
        .taken        (taken),
        .uncond       (uncond),
        .annul_bit    (annul_bit),
        .target       (target),
        .redirect     (redirect),
        .redirect_addr(redirect_addr),
        .pc           (pc),
        .npc          (npc),
        .slot_valid   (slot_valid),
        .taken_count  (taken_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc", pc, m_pc);
            chk("npc", npc, m_npc);
            chk("slot_valid", {31'd0, slot_valid}, {31'd0, m_started && !m_annulled});
`ifdef PC_SEQ_TAKEN_COUNT_EN
            chk("taken_count", taken_count, m_cnt);
`else
            chk("taken_count", taken_count, 32'd0);
`endif
        end
    end

    task automatic model_reset();
        m_pc       = 32'h0;
        m_npc      = 32'h4;
        m_cnt      = 32'h0;
        m_started  = 1'b0;
        m_annulled = 1'b0;
    endtask

    // Effect of one clock edge on the model, given the inputs presented.
    task automatic model_edge();
        logic [31:0] dest;
        if (redirect) begin
            dest       = {redirect_addr[31:2], 2'b00};
            m_pc       = dest;
            m_npc      = dest + 32'd4;
            m_started  = 1'b1;
            m_annulled = 1'b0;
        end else if (stall) begin
            // nothing moves
        end else if (!m_started) begin
            m_started = 1'b1;
        end else begin
            dest = m_npc + 32'd4;
            // A branch in an annulled slot never executes, so it has no effect.
            if (!m_annulled && cti_valid) begin
                if (taken || uncond) begin
                    dest  = {target[31:2], 2'b00};
                    m_cnt = m_cnt + 32'd1;
                end
                m_pc       = m_npc;
                m_npc      = dest;
                m_annulled = annul_bit && (!taken || uncond);
            end else begin
                m_pc       = m_npc;
                m_npc      = dest;
                m_annulled = 1'b0;
            end
        end
    endtask

    // Present inputs, let one edge pass, update the model.
    task automatic step(input bit st, input bit cv, input bit tk, input bit un, input bit an,
                        input logic [31:0] tg, input bit rd, input logic [31:0] ra);
        stall         = st;
        cti_valid     = cv;
        taken         = tk;
        uncond        = un;
        annul_bit     = an;
        target        = tg;
        redirect      = rd;
        redirect_addr = ra;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    endtask

    task automatic go_to(input logic [31:0] a);
        step(0, 0, 0, 0, 0, 32'h0, 1, a);
    endtask

    task automatic sync_reset_seq();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        chk_en   = 1'b0;
        rst_n    = 1'b0;
        stall = 0; cti_valid = 0; taken = 0; uncond = 0; annul_bit = 0;
        target = 0; redirect = 0; redirect_addr = 0;
        model_reset();
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        chk("reset pc", pc, 32'h0);
        chk("reset npc", npc, 32'h4);
        chk("reset slot_valid", {31'd0, slot_valid}, 32'd0);
        chk("reset taken_count", taken_count, 32'd0);
        rst_n = 1'b1;

        // Boot then sequential run
        idle();
        chk("boot pc", pc, 32'h0);
        chk("boot valid", {31'd0, slot_valid}, 32'd1);
        idle();
        chk("seq pc 4", pc, 32'h4);
        idle();
        chk("seq pc 8", pc, 32'h8);
        chk("seq npc 12", npc, 32'hC);

        // Taken branch, no annul
        step(0, 1, 1, 0, 0, 32'h40, 0, 32'h0);
        chk("br slot pc", pc, 32'hC);
        chk("br slot valid", {31'd0, slot_valid}, 32'd1);
        idle();
        chk("br target pc", pc, 32'h40);
        idle();
        chk("br after pc", pc, 32'h44);

        // Untaken with annul
        go_to(32'h8);
        step(0, 1, 0, 0, 1, 32'h80, 0, 32'h0);
        chk("nt annul pc", pc, 32'hC);
        chk("nt annul valid", {31'd0, slot_valid}, 32'd0);
        idle();
        chk("nt after pc", pc, 32'h10);
        chk("nt after valid", {31'd0, slot_valid}, 32'd1);

        // BA,a then stall in SQUASH then redirect under stall
        go_to(32'h8);
        step(0, 1, 1, 1, 1, 32'h100, 0, 32'h0);
        chk("ba annul pc", pc, 32'hC);
        chk("ba annul valid", {31'd0, slot_valid}, 32'd0);
        for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0, 32'h300, 0, 32'h0);
        chk("stall pc", pc, 32'hC);
        chk("stall npc", npc, 32'h100);
        chk("stall valid", {31'd0, slot_valid}, 32'd0);
        step(1, 0, 0, 0, 0, 32'h0, 1, 32'h203);
        chk("redir pc", pc, 32'h200);
        chk("redir npc", npc, 32'h204);
        chk("redir valid", {31'd0, slot_valid}, 32'd1);

        // Wrap
        go_to(32'hFFFF_FFF8);
        idle();
        chk("wrap pc", pc, 32'hFFFF_FFFC);
        chk("wrap npc", npc, 32'h0);

        // Taken counter: 5 taken, 3 not taken, 1 redirect
        sync_reset_seq();
        idle();
        for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0, 32'h1000 + i * 16, 0, 32'h0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 32'h2000, 0, 32'h0);
        go_to(32'h400);
`ifdef PC_SEQ_TAKEN_COUNT_EN
        chk("count five", taken_count, 32'd5);
`else
        chk("count off", taken_count, 32'd0);
`endif

        // Randomized run
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                #2;
                rst_n = 1'b0;
                model_reset();
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end else begin
                step($urandom_range(0, 99) < 20,
                     $urandom_range(0, 99) < 40,
                     $urandom_range(0, 1) == 1,
                     $urandom_range(0, 99) < 25,
                     $urandom_range(0, 1) == 1,
                     $urandom,
                     $urandom_range(0, 99) < 4,
                     (i % 97 == 0) ? 32'hFFFF_FFF6 : $urandom);
            end
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
